// File: rtl/dtl_slave_mem.sv
// DTL slave responder backed by a single-port synchronous SRAM (1-cycle read latency).
// Accepts single/burst commands, streams write beats to memory, and returns read
// beats through a 4-entry buffer so ReadAccept may stall at any point.
module dtl_slave_mem #(
  parameter int unsigned INTERFACE_WIDTH       = 32,
  parameter int unsigned INTERFACE_ADDR_WIDTH  = 32,
  parameter int unsigned INTERFACE_BLOCK_WIDTH = 5,
  parameter int unsigned MEM_ADDR_WIDTH        = 10
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic                              iDTL_CommandValid,
  output logic                              oDTL_CommandAccept,
  input  logic                              iDTL_CommandReadWrite,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]   iDTL_Address,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0]  iDTL_BlockSize,
  input  logic                              iDTL_WriteValid,
  output logic                              oDTL_WriteAccept,
  input  logic [INTERFACE_WIDTH-1:0]        iDTL_WriteData,
  input  logic [INTERFACE_WIDTH/8-1:0]      iDTL_WriteEnable,
  input  logic                              iDTL_WriteLast,
  output logic                              oDTL_ReadValid,
  input  logic                              iDTL_ReadAccept,
  output logic [INTERFACE_WIDTH-1:0]        oDTL_ReadData,
  output logic                              oDTL_ReadLast,
  output logic [MEM_ADDR_WIDTH-1:0]         oMem_Address,
  output logic [INTERFACE_WIDTH/8-1:0]      oMem_WriteEnable,
  output logic [INTERFACE_WIDTH-1:0]        oMem_WriteData,
  output logic                              oMem_ReadEnable,
  input  logic [INTERFACE_WIDTH-1:0]        iMem_ReadData,
  output logic                              oError
);

  localparam int unsigned BYTES      = INTERFACE_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(BYTES);
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic                               cmd_acc_q, cmd_acc_d;
  logic                               wr_acc_q, wr_acc_d;
  logic [MEM_ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [INTERFACE_BLOCK_WIDTH-1:0]   cnt_q, cnt_d;
  logic                               rd_pend_q, rd_pend_d;
  logic [MEM_ADDR_WIDTH-1:0]          mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]                   mem_we_q, mem_we_d;
  logic [INTERFACE_WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
  logic                               mem_re_q, mem_re_d;
  logic                               mem_re_last_q, mem_re_last_d;
  logic                               rd_vld_q, rd_vld_d;
  logic                               rd_vld_last_q, rd_vld_last_d;
  logic                               err_q, err_d;
  logic [1:0]                         wptr_q, wptr_d;
  logic [1:0]                         rptr_q, rptr_d;
  logic [2:0]                         fifo_cnt_q, fifo_cnt_d;
  logic [FIFO_DEPTH-1:0]              fifo_last_q, fifo_last_d;
  logic [INTERFACE_WIDTH-1:0]         fifo_data_q [FIFO_DEPTH];
  logic [INTERFACE_WIDTH-1:0]         fifo_data_d [FIFO_DEPTH];

  logic [INTERFACE_ADDR_WIDTH-1:0]    addr_shifted;
  logic                               fifo_push;
  logic                               fifo_pop;
  logic                               fifo_valid;
  logic [2:0]                         occupancy;

  // Next-state logic for the command FSM, memory stage, read pipeline and FIFO
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    rd_pend_d     = rd_pend_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = '0;
    mem_re_d      = 1'b0;
    mem_re_last_d = 1'b0;
    rd_vld_d      = mem_re_q;
    rd_vld_last_d = mem_re_last_q;
    err_d         = err_q;
    addr_shifted  = iDTL_Address >> BYTE_SHIFT;

    fifo_valid = (fifo_cnt_q != '0);
    fifo_push  = rd_vld_q;
    fifo_pop   = fifo_valid && iDTL_ReadAccept;
    // Reads already issued but not yet in the FIFO still need a slot reserved.
    occupancy  = fifo_cnt_q + {2'b00, mem_re_q} + {2'b00, rd_vld_q};

    case (state_q)
      ST_IDLE: begin
        if (iDTL_CommandValid && cmd_acc_q) begin
          addr_d = addr_shifted[MEM_ADDR_WIDTH-1:0];
          cnt_d  = iDTL_BlockSize;
          if (iDTL_CommandReadWrite) begin
            state_d = ST_WRITE;
          end else begin
            state_d   = ST_READ;
            rd_pend_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (iDTL_WriteValid && wr_acc_q) begin
          mem_addr_d  = addr_q;
          mem_wdata_d = iDTL_WriteData;
          mem_we_d    = iDTL_WriteEnable;
          addr_d      = addr_q + 1'b1;
          cnt_d       = cnt_q - 1'b1;
          if ((cnt_q == '0) || iDTL_WriteLast) begin
            state_d = ST_IDLE;
            if ((cnt_q == '0) != iDTL_WriteLast) begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        if (rd_pend_q && (occupancy < 3'd4)) begin
          mem_addr_d    = addr_q;
          mem_re_d      = 1'b1;
          mem_re_last_d = (cnt_q == '0);
          addr_d        = addr_q + 1'b1;
          if (cnt_q == '0) begin
            rd_pend_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        if (fifo_pop && fifo_last_q[rptr_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_acc_d = (state_d == ST_IDLE);
    wr_acc_d  = (state_d == ST_WRITE);

    wptr_d      = wptr_q + {1'b0, fifo_push};
    rptr_d      = rptr_q + {1'b0, fifo_pop};
    fifo_cnt_d  = fifo_cnt_q + {2'b00, fifo_push} - {2'b00, fifo_pop};
    fifo_last_d = fifo_last_q;
    fifo_data_d = fifo_data_q;
    if (fifo_push) begin
      fifo_last_d[wptr_q] = rd_vld_last_q;
      fifo_data_d[wptr_q] = iMem_ReadData;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q       <= ST_IDLE;
      cmd_acc_q     <= 1'b1;
      wr_acc_q      <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      rd_pend_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= '0;
      mem_wdata_q   <= '0;
      mem_re_q      <= 1'b0;
      mem_re_last_q <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_vld_last_q <= 1'b0;
      err_q         <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      fifo_cnt_q    <= '0;
      fifo_last_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_acc_q     <= cmd_acc_d;
      wr_acc_q      <= wr_acc_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      rd_pend_q     <= rd_pend_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_re_q      <= mem_re_d;
      mem_re_last_q <= mem_re_last_d;
      rd_vld_q      <= rd_vld_d;
      rd_vld_last_q <= rd_vld_last_d;
      err_q         <= err_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_last_q   <= fifo_last_d;
    end
  end

  // Read-buffer payload storage; validity is tracked by the reset pointers
  always_ff @(posedge iClk) begin
    fifo_data_q <= fifo_data_d;
  end

  assign oDTL_CommandAccept = cmd_acc_q;
  assign oDTL_WriteAccept   = wr_acc_q;
  assign oDTL_ReadValid     = (fifo_cnt_q != '0);
  assign oDTL_ReadData      = (fifo_cnt_q != '0) ? fifo_data_q[rptr_q] : '0;
  assign oDTL_ReadLast      = (fifo_cnt_q != '0) && fifo_last_q[rptr_q];
  assign oMem_Address       = mem_addr_q;
  assign oMem_WriteEnable   = mem_we_q;
  assign oMem_WriteData     = mem_wdata_q;
  assign oMem_ReadEnable    = mem_re_q;
  assign oError             = err_q;

endmodule

// File: tb/tb_dtl_slave_mem.sv
// Directed bench for dtl_slave_mem: behavioural SRAM, shadow memory model and a
// read-beat scoreboard queue filled when read commands are issued.
module tb_dtl_slave_mem;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iDTL_CommandValid;
  logic        oDTL_CommandAccept;
  logic        iDTL_CommandReadWrite;
  logic [31:0] iDTL_Address;
  logic [4:0]  iDTL_BlockSize;
  logic        iDTL_WriteValid;
  logic        oDTL_WriteAccept;
  logic [31:0] iDTL_WriteData;
  logic [3:0]  iDTL_WriteEnable;
  logic        iDTL_WriteLast;
  logic        oDTL_ReadValid;
  logic        iDTL_ReadAccept;
  logic [31:0] oDTL_ReadData;
  logic        oDTL_ReadLast;
  logic [9:0]  oMem_Address;
  logic [3:0]  oMem_WriteEnable;
  logic [31:0] oMem_WriteData;
  logic        oMem_ReadEnable;
  logic [31:0] iMem_ReadData;
  logic        oError;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram    [1024];
  logic [31:0] exp_mem [1024];
  logic [31:0] wd      [32];
  logic [3:0]  wbe     [32];
  logic [32:0] sb      [$];

  dtl_slave_mem #(
    .INTERFACE_WIDTH(32),
    .INTERFACE_ADDR_WIDTH(32),
    .INTERFACE_BLOCK_WIDTH(5),
    .MEM_ADDR_WIDTH(10)
  ) dut (
    .iClk(iClk),
    .iReset(iReset),
    .iDTL_CommandValid(iDTL_CommandValid),
    .oDTL_CommandAccept(oDTL_CommandAccept),
    .iDTL_CommandReadWrite(iDTL_CommandReadWrite),
    .iDTL_Address(iDTL_Address),
    .iDTL_BlockSize(iDTL_BlockSize),
    .iDTL_WriteValid(iDTL_WriteValid),
    .oDTL_WriteAccept(oDTL_WriteAccept),
    .iDTL_WriteData(iDTL_WriteData),
    .iDTL_WriteEnable(iDTL_WriteEnable),
    .iDTL_WriteLast(iDTL_WriteLast),
    .oDTL_ReadValid(oDTL_ReadValid),
    .iDTL_ReadAccept(iDTL_ReadAccept),
    .oDTL_ReadData(oDTL_ReadData),
    .oDTL_ReadLast(oDTL_ReadLast),
    .oMem_Address(oMem_Address),
    .oMem_WriteEnable(oMem_WriteEnable),
    .oMem_WriteData(oMem_WriteData),
    .oMem_ReadEnable(oMem_ReadEnable),
    .iMem_ReadData(iMem_ReadData),
    .oError(oError)
  );

  always #5 iClk = ~iClk;

  // Single-port SRAM with byte strobes and one-cycle read latency
  always @(posedge iClk) begin
    for (int b = 0; b < 4; b++) begin
      if (oMem_WriteEnable[b]) sram[oMem_Address][8*b +: 8] <= oMem_WriteData[8*b +: 8];
    end
    if (oMem_ReadEnable) iMem_ReadData <= sram[oMem_Address];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [31:0] baddr, input logic [4:0] bs);
    int n = 0;
    while (oDTL_CommandAccept !== 1'b1 && n < 50) begin
      @(negedge iClk);
      n++;
    end
    check("cmd_accept", oDTL_CommandAccept, 1);
    iDTL_CommandValid     = 1'b1;
    iDTL_CommandReadWrite = rw;
    iDTL_Address          = baddr;
    iDTL_BlockSize        = bs;
    @(negedge iClk);
    iDTL_CommandValid = 1'b0;
  endtask

  task automatic mem_stage_check(input logic [9:0] a, input int j);
    check("mem_we", oMem_WriteEnable, wbe[j]);
    check("mem_addr", oMem_Address, a);
    check("mem_wdata", oMem_WriteData, wd[j]);
    for (int b = 0; b < 4; b++) begin
      if (wbe[j][b]) exp_mem[a][8*b +: 8] = wd[j][8*b +: 8];
    end
  endtask

  task automatic write_burst(input logic [31:0] baddr, input logic [4:0] bs,
                             input int nbeats, input int last_idx);
    logic [9:0] wa;
    wa = baddr[11:2];
    send_cmd(1'b1, baddr, bs);
    for (int i = 0; i < nbeats; i++) begin
      iDTL_WriteValid  = 1'b1;
      iDTL_WriteData   = wd[i];
      iDTL_WriteEnable = wbe[i];
      iDTL_WriteLast   = (i == last_idx);
      check("wr_accept", oDTL_WriteAccept, 1);
      if (i > 0) mem_stage_check(wa + 10'(i - 1), i - 1);
      @(negedge iClk);
    end
    iDTL_WriteValid = 1'b0;
    iDTL_WriteLast  = 1'b0;
    mem_stage_check(wa + 10'(nbeats - 1), nbeats - 1);
    check("wr_accept_end", oDTL_WriteAccept, 0);
    @(negedge iClk);
    check("mem_we_idle", oMem_WriteEnable, 0);
    check("cmd_accept_after_wr", oDTL_CommandAccept, 1);
  endtask

  // mode 0: ReadAccept always 1; mode 1: pattern 1,0,0 repeating.
  // abort_at >= 0: assert reset while beat (abort_at+1) is presented.
  task automatic read_burst(input logic [31:0] baddr, input logic [4:0] bs,
                            input int mode, input int abort_at);
    logic [9:0] wa;
    int issued = 0, popped = 0, first_re = -1, first_rv = -1;
    logic done = 1'b0, aborted = 1'b0, acc;
    logic [32:0] e;
    wa = baddr[11:2];
    send_cmd(1'b0, baddr, bs);
    for (int i = 0; i <= int'(bs); i++) sb.push_back({(i == int'(bs)), exp_mem[wa + 10'(i)]});
    for (int cyc = 1; cyc < 300 && !done && !aborted; cyc++) begin
      if (oMem_ReadEnable === 1'b1) begin
        issued++;
        if (first_re < 0) first_re = cyc;
      end
      check("outstanding_le4", (issued - popped) <= 4, 1);
      if (oDTL_ReadValid === 1'b1 && first_rv < 0) first_rv = cyc;
      acc = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
      if (abort_at >= 0 && popped == abort_at && oDTL_ReadValid === 1'b1) begin
        iReset          = 1'b1;
        iDTL_ReadAccept = 1'b0;
        @(negedge iClk);
        check("rst_read_valid", oDTL_ReadValid, 0);
        check("rst_cmd_accept", oDTL_CommandAccept, 1);
        check("rst_mem_re", oMem_ReadEnable, 0);
        check("rst_error", oError, 0);
        iReset = 1'b0;
        sb.delete();
        aborted = 1'b1;
      end else begin
        iDTL_ReadAccept = acc;
        if (oDTL_ReadValid === 1'b1) begin
          if (sb.size() == 0) begin
            check("read_extra_beat", oDTL_ReadValid, 0);
          end else begin
            e = sb[0];
            check("read_data", oDTL_ReadData, e[31:0]);
            check("read_last", oDTL_ReadLast, e[32]);
            if (acc) begin
              void'(sb.pop_front());
              popped++;
              if (e[32]) done = 1'b1;
            end
          end
        end
        @(negedge iClk);
      end
    end
    iDTL_ReadAccept = 1'b0;
    check("first_mem_re_cycle", first_re, 2);
    check("first_read_valid_cycle", first_rv, 4);
    if (!aborted) begin
      check("read_done", done, 1);
      check("read_beats", popped, int'(bs) + 1);
      check("cmd_accept_after_rd", oDTL_CommandAccept, 1);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    iReset = 1'b1;
    iDTL_CommandValid = 1'b0; iDTL_CommandReadWrite = 1'b0;
    iDTL_Address = '0; iDTL_BlockSize = '0;
    iDTL_WriteValid = 1'b0; iDTL_WriteData = '0; iDTL_WriteEnable = '0; iDTL_WriteLast = 1'b0;
    iDTL_ReadAccept = 1'b0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    repeat (3) @(negedge iClk);
    check("rst_cmd_accept", oDTL_CommandAccept, 1);
    check("rst_wr_accept", oDTL_WriteAccept, 0);
    check("rst_read_valid", oDTL_ReadValid, 0);
    check("rst_read_data", oDTL_ReadData, 0);
    check("rst_read_last", oDTL_ReadLast, 0);
    check("rst_mem_addr", oMem_Address, 0);
    check("rst_mem_we", oMem_WriteEnable, 0);
    check("rst_mem_wdata", oMem_WriteData, 0);
    check("rst_mem_re", oMem_ReadEnable, 0);
    check("rst_error", oError, 0);
    iReset = 1'b0;
    @(negedge iClk);

    // single write then single read
    wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    write_burst(32'h10, 5'd0, 1, 0);
    read_burst(32'h10, 5'd0, 0, -1);

    // byte enables over zeroed words
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h0; wbe[i] = 4'hF; end
    write_burst(32'h40, 5'd3, 4, 3);
    for (int i = 0; i < 4; i++) wd[i] = 32'h11223344;
    wbe[0] = 4'hF; wbe[1] = 4'h1; wbe[2] = 4'h8; wbe[3] = 4'h0;
    write_burst(32'h40, 5'd3, 4, 3);
    read_burst(32'h40, 5'd3, 0, -1);

    // back-pressure on an 8-beat read
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hA5000000 + 32'(i) * 32'h01010101; wbe[i] = 4'hF; end
    write_burst(32'h100, 5'd7, 8, 7);
    read_burst(32'h100, 5'd7, 1, -1);

    // address wrap-around at the top of the SRAM
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); wbe[i] = 4'hF; end
    write_burst(32'hFF8, 5'd3, 4, 3);
    read_burst(32'hFF8, 5'd3, 0, -1);

    // protocol error: WriteLast on beat 2 of a 4-beat burst
    check("error_before", oError, 0);
    wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; wbe[0] = 4'hF; wbe[1] = 4'hF;
    write_burst(32'h200, 5'd3, 2, 1);
    check("error_set", oError, 1);
    read_burst(32'h200, 5'd1, 0, -1);
    check("error_sticky", oError, 1);

    // reset during beat 3 of an 8-beat read, then a clean read
    read_burst(32'h100, 5'd7, 0, 2);
    read_burst(32'h100, 5'd7, 0, -1);
    check("error_final", oError, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
